// File: rtl/pll_phase_sweep_ctrl.sv
// Steps rPLL PSDA through 16 phases, scores phase-detector hits per step,
// then parks the PLL on the best-scoring phase.
module pll_phase_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int SAMPLE_CYCLES = 256,
  parameter int CNT_W         = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pll_lock,
  input  logic             pd_hit,
  output logic [3:0]       psda,
  output logic [3:0]       dutyda,
  output logic             busy,
  output logic             done,
  output logic             lock_err,
  output logic [3:0]       best_step,
  output logic [CNT_W-1:0] best_count
);

  localparam int MAXC = (SETTLE_CYCLES > SAMPLE_CYCLES) ?
                        SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_FINAL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_tmr;
  logic [CNT_W-1:0] r_hit;
  logic [3:0]       r_cur;
  logic [3:0]       r_run_step;
  logic [CNT_W-1:0] r_run_cnt;
  logic [3:0]       r_psda;
  logic [3:0]       r_dutyda;
  logic             r_busy;
  logic             r_done;
  logic             r_lock_err;
  logic [3:0]       r_best_step;
  logic [CNT_W-1:0] r_best_cnt;

  logic w_settle_end;
  logic w_sample_end;
  logic w_active;
  logic w_abort;

  assign w_settle_end = (r_tmr == TW'(SETTLE_CYCLES - 1));
  assign w_sample_end = (r_tmr == TW'(SAMPLE_CYCLES - 1));
  assign w_active     = (r_state == ST_APPLY)  ||
                        (r_state == ST_SETTLE) ||
                        (r_state == ST_SAMPLE) ||
                        (r_state == ST_EVAL);
  assign w_abort      = w_active && !pll_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (start) w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (pll_lock) w_next = ST_APPLY;
      ST_APPLY:     w_next = ST_SETTLE;
      ST_SETTLE:    if (w_settle_end) w_next = ST_SAMPLE;
      ST_SAMPLE:    if (w_sample_end) w_next = ST_EVAL;
      ST_EVAL:      w_next = (r_cur == 4'd15) ? ST_FINAL : ST_APPLY;
      ST_FINAL:     w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr       <= '0;
      r_hit       <= '0;
      r_cur       <= '0;
      r_run_step  <= '0;
      r_run_cnt   <= '0;
      r_psda      <= 4'd0;
      r_dutyda    <= 4'd8;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lock_err  <= 1'b0;
      r_best_step <= '0;
      r_best_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        // psda and best_* intentionally hold their last values
        r_busy     <= 1'b0;
        r_lock_err <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_busy     <= 1'b1;
              r_lock_err <= 1'b0;
              r_cur      <= '0;
              r_run_step <= '0;
              r_run_cnt  <= '0;
            end
          end
          ST_APPLY: begin
            r_psda   <= r_cur;
            r_dutyda <= r_cur + 4'd8;
            r_tmr    <= '0;
            r_hit    <= '0;
          end
          ST_SETTLE: begin
            r_tmr <= w_settle_end ? '0 : r_tmr + 1'b1;
          end
          ST_SAMPLE: begin
            r_tmr <= r_tmr + 1'b1;
            r_hit <= r_hit + CNT_W'(pd_hit);
          end
          ST_EVAL: begin
            // strict compare: ties keep the lower step
            if (r_hit > r_run_cnt) begin
              r_run_step <= r_cur;
              r_run_cnt  <= r_hit;
            end
            if (r_cur != 4'd15) r_cur <= r_cur + 4'd1;
          end
          ST_FINAL: begin
            r_psda      <= r_run_step;
            r_dutyda    <= r_run_step + 4'd8;
            r_best_step <= r_run_step;
            r_best_cnt  <= r_run_cnt;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign psda       = r_psda;
  assign dutyda     = r_dutyda;
  assign busy       = r_busy;
  assign done       = r_done;
  assign lock_err   = r_lock_err;
  assign best_step  = r_best_step;
  assign best_count = r_best_cnt;

endmodule

// File: tb/tb_pll_phase_sweep_ctrl.sv
// Directed bench for pll_phase_sweep_ctrl: expected sweep results are
// queued at start and checked when done pulses.
module tb_pll_phase_sweep_ctrl;

  localparam int S   = 4;
  localparam int P   = 8;
  localparam int CW  = 9;
  localparam int LAT = 2 + 16 * (S + P + 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pll_lock;
  logic          pd_hit;
  logic [3:0]    psda;
  logic [3:0]    dutyda;
  logic          busy;
  logic          done;
  logic          lock_err;
  logic [3:0]    best_step;
  logic [CW-1:0] best_count;

  logic [15:0]   mask;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  typedef struct {
    logic [3:0]    step;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  pll_phase_sweep_ctrl #(
    .SETTLE_CYCLES(S),
    .SAMPLE_CYCLES(P),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pll_lock  (pll_lock),
    .pd_hit    (pd_hit),
    .psda      (psda),
    .dutyda    (dutyda),
    .busy      (busy),
    .done      (done),
    .lock_err  (lock_err),
    .best_step (best_step),
    .best_count(best_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pd_hit = mask[psda];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] m);
    exp_t          e;
    logic [CW-1:0] c;
    e.step = '0;
    e.cnt  = '0;
    for (int s = 0; s < 16; s++) begin
      c = m[s] ? CW'(P) : '0;
      if (c > e.cnt) begin
        e.step = 4'(s);
        e.cnt  = c;
      end
    end
    return e;
  endfunction

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_sweep(input string tag, input int t0,
                              input int exp_lat);
    exp_t e;
    int   lat;
    wait_done(t0, exp_lat + 100, lat);
    chk({tag, "_latency"}, lat, exp_lat);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (lat >= 0) begin
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_best_step"}, best_step, e.step);
        chk({tag, "_best_count"}, best_count, e.cnt);
        chk({tag, "_psda"}, psda, e.step);
        chk({tag, "_dutyda"}, dutyda, 4'(e.step + 4'd8));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 1'b0);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    pll_lock = 1'b1;
    mask     = '0;

    // reset and idle
    repeat (3) @(negedge clk);
    chk("rst_psda", psda, 4'd0);
    chk("rst_dutyda", dutyda, 4'd8);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    chk("idle_no_activity", seen, 0);
    chk("idle_psda", psda, 4'd0);
    chk("idle_dutyda", dutyda, 4'd8);
    chk("idle_best_step", best_step, 4'd0);
    chk("idle_best_count", best_count, '0);
    chk("idle_lock_err", lock_err, 1'b0);

    // clean sweep, hit only at step 5
    mask = 16'h0020;
    sb.push_back(model(mask));
    pulse_start(t0);
    chk("clean_busy_rise", busy, 1'b1);
    finish_sweep("clean", t0, LAT);

    // tie at steps 3 and 9, plus start re-pulsed while busy
    mask = 16'h0208;
    sb.push_back(model(mask));
    pulse_start(t0);
    while (cyc < t0 + 99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_restart_busy", busy, 1'b1);
    finish_sweep("tie", t0, LAT);

    // no hits anywhere
    mask = 16'h0000;
    sb.push_back(model(mask));
    pulse_start(t0);
    finish_sweep("empty", t0, LAT);

    // lock held low for 50 cycles after start
    mask = 16'h1000;
    pll_lock = 1'b0;
    sb.push_back(model(mask));
    pulse_start(t0);
    repeat (50) @(negedge clk);
    chk("lockwait_psda", psda, 4'd0);
    chk("lockwait_busy", busy, 1'b1);
    pll_lock = 1'b1;
    finish_sweep("lockwait", t0, LAT + 50);

    // lock lost during step 7 SAMPLE
    mask = 16'h0004;
    pulse_start(t0);
    while (cyc < t0 + 106) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_lock_err", lock_err, 1'b1);
    chk("abort_psda", psda, 4'd7);
    chk("abort_dutyda", dutyda, 4'd15);
    chk("abort_best_step", best_step, 4'd12);
    chk("abort_best_count", best_count, CW'(P));
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_lock_err_sticky", lock_err, 1'b1);
    pll_lock = 1'b1;

    // next start clears lock_err
    mask = 16'h4200;
    sb.push_back(model(mask));
    pulse_start(t0);
    chk("restart_lock_err_clr", lock_err, 1'b0);
    finish_sweep("restart", t0, LAT);

    // asynchronous reset during step 10
    mask = 16'h0800;
    pulse_start(t0);
    while (cyc < t0 + 145) @(negedge clk);
    chk("pre_rst_psda", psda, 4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_psda", psda, 4'd0);
    chk("arst_dutyda", dutyda, 4'd8);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_lock_err", lock_err, 1'b0);
    chk("arst_best_step", best_step, 4'd0);
    chk("arst_best_count", best_count, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // sweep after reset completes normally
    mask = 16'h8000;
    sb.push_back(model(mask));
    pulse_start(t0);
    finish_sweep("post_rst", t0, LAT);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_sweep_ctrl.md
# pll_phase_sweep_ctrl

Sequences the dynamic phase-shift inputs of the 250 MHz rPLL used by the phase-detector design. On request, it steps PSDA through all 16 phase settings. At each setting it waits for the output to settle, then counts how often the phase detector reports a hit. It finishes by parking the PLL on the best-scoring setting. The block runs in the fabric clock domain and drives the rPLL PSDA/DUTYDA pins, which must be configured with DYN_DA_EN = "true".

## Interface
Parameters:
- SETTLE_CYCLES, 64: clk cycles to wait after each PSDA change before sampling.
- SAMPLE_CYCLES, 256: clk cycles during which pd_hit is counted per step.
- CNT_W, 9: hit-counter width; must satisfy 2^CNT_W > SAMPLE_CYCLES.

Ports:
- clk  in  1  fabric clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle sweep request; honoured only in IDLE.
- pll_lock  in  1  rPLL LOCK, already synchronised to clk.
- pd_hit  in  1  phase-detector sample, already synchronised to clk.
- psda  out  4  rPLL PSDA, phase step 0..15.
- dutyda  out  4  rPLL DUTYDA; always equals (psda + 8) mod 16 so duty stays at 50%.
- busy  out  1  high from the cycle after start is accepted until done or abort.
- done  out  1  one-cycle pulse when the sweep completes successfully.
- lock_err  out  1  sticky; set on lock loss mid-sweep, cleared by the next accepted start.
- best_step  out  4  winning phase step; updated only on successful completion.
- best_count  out  CNT_W  hit count of the winning step.

## Operation
- Reset values: psda=0, dutyda=8, busy=0, done=0, lock_err=0, best_step=0, best_count=0, FSM in IDLE.
- IDLE: start=1 → WAIT_LOCK; clear lock_err, cur_step=0, run_best_step=0, run_best_count=0.
- WAIT_LOCK: stay while pll_lock=0. No timeout; upstream logic owns the timeout. When pll_lock=1 → APPLY.
- APPLY (1 cycle): psda<=cur_step, dutyda<=cur_step+8; clear settle and hit counters → SETTLE.
- SETTLE: SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: SAMPLE_CYCLES cycles; hit_cnt increments in each cycle where pd_hit=1. Count range is 0..SAMPLE_CYCLES with no saturation logic. → EVAL.
- EVAL (1 cycle):
  - If hit_cnt > run_best_count (strict), update the run best to this step and count. Ties keep the lower step.
  - If cur_step==15 → FINAL; else cur_step+1 → APPLY.
- FINAL (1 cycle):
  - psda<=run_best_step, dutyda<=run_best_step+8.
  - best_step/best_count<=run best; done<=1 → IDLE.
- All hits zero: best_step=0, best_count=0. This still counts as a successful completion and done pulses.
- Lock loss: pll_lock=0 in any of APPLY, SETTLE, SAMPLE or EVAL.
  - Next state is IDLE; lock_err<=1, busy<=0, no done pulse.
  - best_step, best_count and psda are unchanged from their values at abort; psda holds the last applied step.
- start is ignored while busy, including in the FINAL cycle.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- busy rises 1 cycle after the start edge and falls in the same cycle done rises.
- psda/dutyda change one cycle after entering APPLY or FINAL.
- With pll_lock high throughout, done is high exactly 2 + 16·(SETTLE_CYCLES + SAMPLE_CYCLES + 2) cycles after the clk edge that samples start.
- The first counted pd_hit sample is SETTLE_CYCLES+1 cycles after the psda update.

## Test plan
Bench parameters: SETTLE_CYCLES=4, SAMPLE_CYCLES=8.
- Reset/idle: hold rst_n=0 then release, no start → psda=0, dutyda=8, busy=0, done=0, best_*=0 indefinitely.
- Clean sweep: pll_lock=1, pd_hit=1 only while psda==5, start pulse → done exactly 226 cycles later; best_step=5, best_count=8, psda=5, dutyda=13.
- Tie and empty:
  - pd_hit=1 while psda∈{3,9} → best_step=3, best_count=8.
  - pd_hit=0 always → best_step=0, best_count=0, done pulses.
- Lock handling:
  - Hold pll_lock=0 for 50 cycles after start → psda stays 0, busy=1; done arrives 276 cycles after start.
  - Drop pll_lock during step 7 SAMPLE → busy=0, lock_err=1, no done, psda=7.
  - Next start → lock_err clears.
- Start while busy: re-pulse start at cycle 100 of a sweep → no restart; done still arrives at cycle 226.
- Async reset mid-sweep: assert rst_n=0 at step 10 → outputs reach reset values before the next clk edge; a new sweep after release completes normally.
